mem_access_ctrl: RTL

- Data-memory access stage that sits between the execute-stage address/store-data producer and the bus.
- Accepts one load or store request per transaction. Store data and byte strobes arrive already aligned.
- Drives a valid/ready memory bus, captures load data, and returns the word with the latched effective-address low bits to the write-back alignment mux.
- Stalls the pipeline (req_ready low) while a transaction is outstanding.

---
 rtl/mem_access_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Data-memory access stage between the execute-stage address/store-data
//   producer and a valid/ready memory bus. One load or store per transaction;
//   the pipeline is stalled (req_ready low) while a transaction is outstanding.
//   Load data is captured and returned together with the latched effective
//   address low bits for the write-back alignment mux.
//
// Optional feature (compile-time macro): MEM_TIMEOUT_EN
//   Defined   : a WAIT_RD watchdog of TIMEOUT_CYCLES cycles returns an error
//               response (resp_err=1, resp_rdata=0) if no data beat arrives.
//   Undefined : WAIT_RD waits indefinitely, resp_err is always 0.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   req_*                       pipeline request (valid/ready, wen, addr,
//                               aligned wdata, byte strobes)
//   mem_req_*, mem_addr/wen/
//   mem_wdata/mem_strb          bus request channel (word address only)
//   mem_rdata_*                 bus read-data channel
//   resp_*                      response to write-back (rdata, ea, is_store,
//                               err)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_strb,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_strb,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_ea,
  output logic                  resp_is_store,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-3:0] r_waddr;
  logic [1:0]            r_ea;
  logic                  r_wen;
  logic [31:0]           r_wdata;
  logic [3:0]            r_strb;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_timeout;

  // A watchdog shorter than two cycles cannot distinguish entry from expiry.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  // Read beats are only meaningful in WAIT_RD; in IDLE they are drained.
  assign w_beat   = (r_state == ST_WAIT_RD) && mem_rdata_valid;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tcnt;

  // Watchdog: zero outside WAIT_RD (so it is clear on entry), counts inside.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tcnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_WAIT_RD) begin
      r_tcnt <= r_tcnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_tcnt <= {CNT_W{1'b0}};
    end
  end

  assign w_timeout = (r_state == ST_WAIT_RD) && (r_tcnt == CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          // A store with no enabled bytes has nothing to put on the bus.
          if (req_wen && (req_strb == 4'b0000)) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = r_wen ? ST_RESP : ST_WAIT_RD;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT_RD: begin
        // A beat on the expiry cycle also lands here; the datapath lets it win.
        if (mem_rdata_valid || w_timeout) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT_RD;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request/response field capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_waddr <= {(ADDR_WIDTH-2){1'b0}};
      r_ea    <= 2'b00;
      r_wen   <= 1'b0;
      r_wdata <= 32'h0000_0000;
      r_strb  <= 4'b0000;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_waddr <= req_addr[ADDR_WIDTH-1:2];
      r_ea    <= req_addr[1:0];
      r_wen   <= req_wen;
      r_wdata <= req_wdata;
      r_strb  <= req_wen ? req_strb : 4'b0000;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_beat) begin
      r_rdata <= mem_rdata;
    end else if (w_timeout) begin
      r_err   <= 1'b1;
    end
  end

  assign req_ready       = (r_state == ST_IDLE);
  assign mem_req_valid   = (r_state == ST_REQ);
  assign mem_rdata_ready = (r_state == ST_IDLE) || (r_state == ST_WAIT_RD);
  assign resp_valid      = (r_state == ST_RESP);

  assign mem_addr        = {r_waddr, 2'b00};
  assign mem_wen         = r_wen;
  assign mem_wdata       = r_wdata;
  assign mem_strb        = r_strb;

  assign resp_rdata      = r_rdata;
  assign resp_ea         = r_ea;
  assign resp_is_store   = r_wen;
  assign resp_err        = r_err;

endmodule
